// File: rtl/lfsr_period_monitor_pkg.sv
// Shared types and constants for the LFSR period monitor.
package lfsr_period_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DONE    = 2'd2,
        FAULT   = 2'd3
    } state_t;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_STUCK   = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

endpackage

// File: rtl/lfsr_period_monitor_if.sv
// Sample/control inputs and result outputs of the LFSR period monitor.
interface lfsr_period_monitor_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 5
);
    logic [WIDTH-1:0] lfsr_in;
    logic             sample_en;
    logic             start;
    logic             clear;
    logic             busy;
    logic             done;
    logic             fault;
    logic [1:0]       fault_code;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] ones;
    logic [WIDTH-1:0] seed;

    modport master (
        output lfsr_in, sample_en, start, clear,
        input  busy, done, fault, fault_code, period, ones, seed
    );

    modport slave (
        input  lfsr_in, sample_en, start, clear,
        output busy, done, fault, fault_code, period, ones, seed
    );
endinterface

// File: rtl/lfsr_period_monitor.sv
// Measures the period of an LFSR sample stream from a captured seed, counts MSB
// ones over one period, and flags stuck or non-returning sequences.
module lfsr_period_monitor
    import lfsr_period_monitor_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lfsr_period_monitor_if.slave mon
);

    // cnt+1 reaching 2^WIDTH means every state was visited without seeing the seed again
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(1) << WIDTH;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] seed_reg, seed_next;
    logic [WIDTH-1:0] prev_reg, prev_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] ones_reg, ones_next;
    logic [CNT_W-1:0] period_reg, period_next;
    logic [1:0]       fault_code_reg, fault_code_next;

    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] msb_in;

    assign cnt_inc = cnt_reg + CNT_W'(1);
    assign msb_in  = CNT_W'(mon.lfsr_in[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            seed_reg       <= '0;
            prev_reg       <= '0;
            cnt_reg        <= '0;
            ones_reg       <= '0;
            period_reg     <= '0;
            fault_code_reg <= FAULT_NONE;
        end else begin
            state_reg      <= state_next;
            seed_reg       <= seed_next;
            prev_reg       <= prev_next;
            cnt_reg        <= cnt_next;
            ones_reg       <= ones_next;
            period_reg     <= period_next;
            fault_code_reg <= fault_code_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        seed_next       = seed_reg;
        prev_next       = prev_reg;
        cnt_next        = cnt_reg;
        ones_next       = ones_reg;
        period_next     = period_reg;
        fault_code_next = fault_code_reg;

        if (mon.clear) begin
            state_next      = IDLE;
            seed_next       = '0;
            prev_next       = '0;
            cnt_next        = '0;
            ones_next       = '0;
            period_next     = '0;
            fault_code_next = FAULT_NONE;
        end else begin
            case (state_reg)
                MEASURE: begin
                    if (mon.sample_en) begin
                        // Seed match outranks the stuck check so a period-1 stream reads as DONE
                        if (mon.lfsr_in == seed_reg) begin
                            period_next = cnt_inc;
                            state_next  = DONE;
                        end else if (mon.lfsr_in == prev_reg) begin
                            fault_code_next = FAULT_STUCK;
                            state_next      = FAULT;
                        end else if (cnt_inc == FULL_COUNT) begin
                            fault_code_next = FAULT_TIMEOUT;
                            state_next      = FAULT;
                        end else begin
                            cnt_next  = cnt_inc;
                            prev_next = mon.lfsr_in;
                            ones_next = ones_reg + msb_in;
                        end
                    end
                end
                default: begin
                    if (mon.start && mon.sample_en) begin
                        seed_next       = mon.lfsr_in;
                        prev_next       = mon.lfsr_in;
                        cnt_next        = '0;
                        ones_next       = msb_in;
                        period_next     = '0;
                        fault_code_next = FAULT_NONE;
                        state_next      = MEASURE;
                    end
                end
            endcase
        end
    end

    assign mon.busy       = (state_reg == MEASURE);
    assign mon.done       = (state_reg == DONE);
    assign mon.fault      = (state_reg == FAULT);
    assign mon.fault_code = fault_code_reg;
    assign mon.period     = period_reg;
    assign mon.ones       = ones_reg;
    assign mon.seed       = seed_reg;

endmodule

// File: tb/tb_lfsr_period_monitor.sv
// Directed and randomized checks of lfsr_period_monitor against a sequence-level model.
module tb_lfsr_period_monitor;

    localparam int WIDTH = 4;
    localparam int CNT_W = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    logic [3:0] stim[$];

    lfsr_period_monitor_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) m ();

    lfsr_period_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mon   (m.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, ".busy"}, 32'(m.busy), 0);
        chk({tag, ".done"}, 32'(m.done), 0);
        chk({tag, ".fault"}, 32'(m.fault), 0);
        chk({tag, ".code"}, 32'(m.fault_code), 0);
        chk({tag, ".period"}, 32'(m.period), 0);
        chk({tag, ".ones"}, 32'(m.ones), 0);
        chk({tag, ".seed"}, 32'(m.seed), 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // x^4+x^3+1 Fibonacci LFSR: seed followed by n successors
    task automatic build_lfsr(input logic [3:0] s0, input int n);
        logic [3:0] s;
        s = s0;
        stim.delete();
        stim.push_back(s);
        for (int i = 0; i < n; i++) begin
            s = {s[2:0], s[3] ^ s[2]};
            stim.push_back(s);
        end
    endtask

    // Sequence-level reference: the measurement ends at the first sample i>=1 that
    // equals the seed (done, period=i), equals its predecessor (stuck), or is the 16th (timeout).
    // kind: 0 done, 1 stuck, 2 timeout, -1 stream too short.
    task automatic model(output int kind, output int end_i, output int per, output int n_ones);
        kind = -1; end_i = 0; per = 0; n_ones = 0;
        for (int i = 1; i < stim.size(); i++) begin
            if (stim[i] == stim[0])          begin kind = 0; per = i; end
            else if (stim[i] == stim[i-1])   kind = 1;
            else if (i == (1 << WIDTH))      kind = 2;
            if (kind >= 0) begin
                end_i = i;
                break;
            end
        end
        for (int j = 0; j < end_i; j++) n_ones += int'(stim[j][3]);
    endtask

    // Drive stim with random idle gaps; optionally pulse start while busy.
    task automatic run(input string tag, input int gap_min, input int gap_max, input bit poke);
        int kind, end_i, per, n_ones;
        model(kind, end_i, per, n_ones);
        if (kind < 0) begin
            n_fail++;
            $display("FAIL %s.model stream ended without a result", tag);
            return;
        end
        m.sample_en = 1'b1; m.start = 1'b1; m.lfsr_in = stim[0];
        tick();
        m.start = 1'b0;
        chk({tag, ".busy_start"}, 32'(m.busy), 1);
        for (int i = 1; i <= end_i; i++) begin
            repeat ($urandom_range(gap_max, gap_min)) begin
                m.sample_en = 1'b0;
                m.lfsr_in   = 4'($urandom);
                m.start     = poke ? 1'($urandom) : 1'b0;
                tick();
                chk({tag, ".busy_gap"}, 32'(m.busy), 1);
            end
            m.sample_en = 1'b1;
            m.lfsr_in   = stim[i];
            m.start     = poke ? 1'($urandom) : 1'b0;
            tick();
            chk({tag, ".busy"}, 32'(m.busy), (i < end_i) ? 1 : 0);
        end
        m.sample_en = 1'b0; m.start = 1'b0;
        chk({tag, ".done"}, 32'(m.done), (kind == 0) ? 1 : 0);
        chk({tag, ".fault"}, 32'(m.fault), (kind != 0) ? 1 : 0);
        chk({tag, ".code"}, 32'(m.fault_code), kind);
        chk({tag, ".period"}, 32'(m.period), per);
        chk({tag, ".seed"}, 32'(m.seed), 32'(stim[0]));
        if (kind == 0) chk({tag, ".ones"}, 32'(m.ones), n_ones);
        $display("%s: seed=%0h end=%0d kind=%0d period=%0d ones=%0d", tag, stim[0], end_i, kind,
                 m.period, m.ones);
    endtask

    task automatic start_and_feed(input int n);
        m.sample_en = 1'b1; m.start = 1'b1; m.lfsr_in = stim[0];
        tick();
        m.start = 1'b0;
        for (int i = 1; i <= n; i++) begin
            m.lfsr_in = stim[i];
            tick();
        end
    endtask

    initial begin
        m.lfsr_in = '0; m.sample_en = 1'b0; m.start = 1'b0; m.clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_cleared("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // start without a sample is ignored
        m.start = 1'b1; m.sample_en = 1'b0; m.lfsr_in = 4'h1;
        tick();
        chk("start_no_sample.busy", 32'(m.busy), 0);
        m.start = 1'b0;

        build_lfsr(4'h1, 16);
        run("maximal", 0, 0, 1'b0);
        chk("maximal.period15", 32'(m.period), 15);
        chk("maximal.ones8", 32'(m.ones), 8);

        stim = '{4'h0, 4'h0, 4'h0};
        run("zero_lock", 0, 0, 1'b0);

        stim = '{4'h3, 4'h5, 4'h9, 4'h3};
        run("synthetic", 0, 1, 1'b0);

        stim = '{4'h7, 4'h7};
        run("period1", 0, 0, 1'b0);
        chk("period1.done", 32'(m.done), 1);

        stim.delete();
        stim.push_back(4'h0);
        for (int i = 1; i <= 16; i++) stim.push_back((i % 2) ? 4'h1 : 4'h2);
        run("timeout", 0, 0, 1'b0);
        chk("timeout.code", 32'(m.fault_code), 2);

        build_lfsr(4'h1, 16);
        run("gapped", 2, 2, 1'b1);
        chk("gapped.period15", 32'(m.period), 15);

        // asynchronous reset with cnt=7 mid-measure
        build_lfsr(4'h1, 16);
        start_and_feed(7);
        chk("pre_reset.busy", 32'(m.busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_cleared("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        run("after_reset", 0, 1, 1'b0);

        // clear mid-measure
        build_lfsr(4'h1, 16);
        start_and_feed(5);
        m.clear = 1'b1; m.lfsr_in = stim[6];
        tick();
        m.clear = 1'b0;
        chk_cleared("clear");
        run("after_clear", 0, 1, 1'b0);

        for (int t = 0; t < 4; t++) begin
            build_lfsr(4'($urandom_range(15, 1)), 16);
            run("rand_lfsr", 0, 2, 1'b1);
        end
        for (int t = 0; t < 8; t++) begin
            stim.delete();
            for (int i = 0; i < 17; i++)
                stim.push_back((t % 2) ? 4'($urandom_range(3, 0)) : 4'($urandom));
            run("rand_stream", 0, 1, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
